bcd_stream_classifier: RTL and testbench

BCD_STREAM_CLASSIFIER -- requirements
Module: bcd_stream_classifier

---
 rtl/bcd_pkg.sv | 11 +
 rtl/bcd_classify_core.sv | 27 ++
 rtl/bcd_stream_classifier.sv | 106 ++++++++++
 tb/tb_bcd_stream_classifier.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: FSM states, BCD digit type, digit constants and the is_bcd check
//   shared by bcd_classify_core and bcd_stream_classifier.
package bcd_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, EVAL, HOLD} state_t;
  typedef logic [3:0] bcd_t;
  localparam bcd_t BCD_MAX = 4'd9;
  localparam bcd_t HALF = 4'd5;
  function automatic logic is_bcd(input bcd_t d);
    return d <= BCD_MAX;
  endfunction
endpackage

// File: rtl/bcd_classify_core.sv
// bcd_classify_core: combinational ten's-complement classifier of a DIGITS-digit BCD number.
//   i_digits     : BCD digits, most significant digit in the top nibble
//   o_positivo   : number is non-negative (ms digit < 5), 0 when invalid
//   o_riducibile : number fits in DIGITS-1 digits, 0 when invalid
//   o_invalido   : some nibble is greater than 9
module bcd_classify_core import bcd_pkg::*; #(
  parameter int DIGITS = 2
) (
  input  logic [4*DIGITS-1:0] i_digits,
  output logic                o_positivo,
  output logic                o_riducibile,
  output logic                o_invalido
);
  bcd_t w_ms, w_nx;
  logic w_bad;
  assign w_ms = i_digits[4*DIGITS-1 -: 4];
  assign w_nx = i_digits[4*DIGITS-5 -: 4];
  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) w_bad = w_bad | !is_bcd(i_digits[4*i +: 4]);
  end
  // Dropping the top digit is lossless only when it is pure sign extension:
  // 0 followed by a positive digit, or 9 followed by a negative one.
  assign o_invalido = w_bad;
  assign o_positivo = !w_bad && w_ms < HALF;
  assign o_riducibile = !w_bad && ((w_ms == 4'd0 && w_nx < HALF) || (w_ms == BCD_MAX && w_nx >= HALF));
endmodule

// File: rtl/bcd_stream_classifier.sv
// bcd_stream_classifier: fetches DIGITS/2-byte BCD numbers from memory and publishes
//   ten's-complement flags once every PERIOD clocks.
//   clock/reset : rising-edge clock, asynchronous active-high reset
//   run         : enables the fetch/classify loop
//   addr/data   : memory read address (registered) and returned byte (MEM_LAT clocks later)
//   positivo, riducibile, invalido : flags of the last published number
//   valid       : one-clock pulse when the flags update
module bcd_stream_classifier import bcd_pkg::*; #(
  parameter int DIGITS  = 2,
  parameter int ADDR_W  = 16,
  parameter int BASE    = 0,
  parameter int MEM_LAT = 1,
  parameter int PERIOD  = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  output logic [ADDR_W-1:0] addr,
  input  logic [7:0]        data,
  output logic              positivo,
  output logic              riducibile,
  output logic              invalido,
  output logic              valid
);
  localparam int NB = DIGITS / 2;
  localparam int CW = $clog2(PERIOD + 1);
  localparam int WW = $clog2(MEM_LAT + 1);
  localparam int BW = $clog2(NB + 1);
  if (DIGITS != 2 && DIGITS != 4 && DIGITS != 6 && DIGITS != 8) begin : g_bad_digits
    $error("bcd_stream_classifier: DIGITS must be 2, 4, 6 or 8");
  end
  if (MEM_LAT < 1) begin : g_bad_lat
    $error("bcd_stream_classifier: MEM_LAT must be at least 1");
  end
  if (PERIOD < NB * (MEM_LAT + 2) + 2) begin : g_bad_period
    $error("bcd_stream_classifier: PERIOD too short for one fetch/eval cycle");
  end
  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [WW-1:0]   r_wcnt;
  logic [BW-1:0]   r_bidx;
  logic [8*NB-1:0] r_num;
  logic            r_pos_s, r_red_s, r_inv_s;
  logic            w_pos, w_red, w_inv;
  logic            w_last_byte, w_period_end;
  bcd_classify_core #(.DIGITS(DIGITS)) u_core (
    .i_digits    (r_num),
    .o_positivo  (w_pos),
    .o_riducibile(w_red),
    .o_invalido  (w_inv)
  );
  assign w_last_byte = r_bidx == BW'(NB - 1);
  assign w_period_end = r_cnt == CW'(PERIOD - 1);
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_wcnt     <= '0;
      r_bidx     <= '0;
      r_num      <= '0;
      r_pos_s    <= 1'b0;
      r_red_s    <= 1'b0;
      r_inv_s    <= 1'b0;
      addr       <= ADDR_W'(BASE);
      positivo   <= 1'b0;
      riducibile <= 1'b0;
      invalido   <= 1'b0;
      valid      <= 1'b0;
    end else begin
      valid <= 1'b0;
      // The period counter runs from the clock that leaves IDLE regardless of the
      // data path, so result spacing never depends on what was fetched.
      r_cnt <= (r_state == IDLE || w_period_end) ? '0 : r_cnt + 1'b1;
      case (r_state)
        IDLE: r_state <= run ? ISSUE : IDLE;
        ISSUE: begin
          r_wcnt  <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          r_wcnt  <= r_wcnt + 1'b1;
          r_state <= r_wcnt == WW'(MEM_LAT - 1) ? CAPTURE : WAIT;
        end
        CAPTURE: begin
          r_num   <= (r_num << 8) | (8*NB)'(data);
          addr    <= addr + 1'b1;
          r_bidx  <= w_last_byte ? '0 : r_bidx + 1'b1;
          r_state <= w_last_byte ? EVAL : ISSUE;
        end
        EVAL: begin
          r_pos_s <= w_pos;
          r_red_s <= w_red;
          r_inv_s <= w_inv;
          r_state <= HOLD;
        end
        HOLD: if (w_period_end) begin
          positivo   <= r_pos_s;
          riducibile <= r_red_s;
          invalido   <= r_inv_s;
          valid      <= 1'b1;
          r_state    <= run ? ISSUE : IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_bcd_stream_classifier.sv
// tb_bcd_stream_classifier: three classifier instances (2-digit default, 4-digit,
//   4-bit wrapping address with MEM_LAT=2) against an arithmetic reference model.
module tb_bcd_stream_classifier;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [2:0] rst_v = '0, run_v = '0, pos_v, red_v, inv_v, val_v;
  logic [7:0] data_a, data_b, data_c, data_cp;
  logic [15:0] addr_a, addr_b;
  logic [3:0] addr_c;
  logic [7:0] mem [3][256];
  int nb_k[3] = '{1, 2, 1};
  int per_k[3] = '{10, 10, 7};
  int base_k[3] = '{0, 0, 14};
  int mask_k[3] = '{255, 255, 15};
  int ptr[3], vcnt[3], lastv[3];
  bit seq[3];
  logic [2:0] last_fl[3];
  int cyc, n_chk, n_err;
  typedef struct { int k; int n; logic [2:0] fl; int ad; } vec_t;
  vec_t tbl[6];

  bcd_stream_classifier u_a (
    .clock(clk), .reset(rst_v[0]), .run(run_v[0]), .addr(addr_a), .data(data_a),
    .positivo(pos_v[0]), .riducibile(red_v[0]), .invalido(inv_v[0]), .valid(val_v[0]));
  bcd_stream_classifier #(.DIGITS(4)) u_b (
    .clock(clk), .reset(rst_v[1]), .run(run_v[1]), .addr(addr_b), .data(data_b),
    .positivo(pos_v[1]), .riducibile(red_v[1]), .invalido(inv_v[1]), .valid(val_v[1]));
  bcd_stream_classifier #(.ADDR_W(4), .BASE(14), .MEM_LAT(2), .PERIOD(7)) u_c (
    .clock(clk), .reset(rst_v[2]), .run(run_v[2]), .addr(addr_c), .data(data_c),
    .positivo(pos_v[2]), .riducibile(red_v[2]), .invalido(inv_v[2]), .valid(val_v[2]));

  always @(posedge clk) begin
    data_a  <= mem[0][addr_a[7:0]];
    data_b  <= mem[1][addr_b[7:0]];
    data_cp <= mem[2][{4'h0, addr_c}];
    data_c  <= data_cp;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  function automatic int addr_of(input int k);
    return k == 0 ? int'(addr_a) : k == 1 ? int'(addr_b) : int'(addr_c);
  endfunction

  function automatic logic [2:0] flags_of(input int k);
    return {pos_v[k], red_v[k], inv_v[k]};
  endfunction

  function automatic logic [7:0] rand_byte();
    logic [3:0] h, l;
    h = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
    l = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
    return {h, l};
  endfunction

  // Decimal value -> signed ten's-complement value -> range tests.
  function automatic logic [2:0] ref_flags(input int k, input int p);
    longint n = 0, full = 1, v, h;
    bit bad = 0;
    for (int i = 0; i < nb_k[k]; i++) begin
      logic [7:0] b;
      b = mem[k][(p + i) & mask_k[k]];
      if (b[7:4] > 9 || b[3:0] > 9) bad = 1;
      n = n * 100 + longint'(b[7:4]) * 10 + longint'(b[3:0]);
      full = full * 100;
    end
    if (bad) return 3'b001;
    v = (n >= full / 2) ? n - full : n;
    h = full / 20;
    return {v >= 0, v >= -h && v < h, 1'b0};
  endfunction

  initial forever begin
    @(negedge clk);
    cyc++;
    for (int k = 0; k < 3; k++) begin
      logic [2:0] fl;
      fl = flags_of(k);
      if (rst_v[k]) begin
        chk($sformatf("reset_outputs%0d", k), {fl, val_v[k]}, 0);
        chk($sformatf("reset_addr%0d", k), addr_of(k), base_k[k]);
        ptr[k] = base_k[k];
        seq[k] = 0;
      end else begin
        if (val_v[k]) begin
          chk($sformatf("flags%0d@%0d", k, ptr[k]), fl, ref_flags(k, ptr[k]));
          ptr[k] = (ptr[k] + nb_k[k]) & mask_k[k];
          chk($sformatf("addr_at_valid%0d", k), addr_of(k), ptr[k]);
          if (seq[k]) chk($sformatf("gap%0d", k), cyc - lastv[k], per_k[k]);
          lastv[k] = cyc;
          seq[k] = 1;
          vcnt[k]++;
        end else chk($sformatf("hold%0d", k), fl, last_fl[k]);
        if (!run_v[k]) seq[k] = 0;
      end
      last_fl[k] = fl;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_v(input int k, input int n);
    int lim;
    lim = (n - vcnt[k] + 2) * per_k[k] * 2 + 20;
    for (int t = 0; t < lim && vcnt[k] < n; t++) tick();
    chk($sformatf("wait_valid%0d_n%0d", k, n), vcnt[k] >= n, 1);
  endtask

  initial begin
    int n0, v0, v1;
    for (int k = 0; k < 3; k++)
      for (int a = 0; a < 256; a++) mem[k][a] = rand_byte();
    mem[0][0] = 8'h03; mem[0][1] = 8'h47; mem[0][2] = 8'h96; mem[0][3] = 8'h5A;
    mem[1][0] = 8'h99; mem[1][1] = 8'h87; mem[1][2] = 8'h00; mem[1][3] = 8'h12;
    tbl[0] = '{0, 1, 3'b110, 1};
    tbl[1] = '{1, 1, 3'b010, 2};
    tbl[2] = '{0, 2, 3'b100, 2};
    tbl[3] = '{1, 2, 3'b110, 4};
    tbl[4] = '{0, 3, 3'b010, 3};
    tbl[5] = '{0, 4, 3'b001, 4};
    #1 rst_v = 3'b111;
    repeat (3) tick();
    rst_v = 3'b000;
    run_v = 3'b011;
    n0 = cyc;
    wait_v(0, 1);
    chk("first_latency_a", lastv[0] - n0, 11);
    for (int i = 0; i < 6; i++) begin
      wait_v(tbl[i].k, tbl[i].n);
      chk($sformatf("tbl%0d_flags", i), flags_of(tbl[i].k), tbl[i].fl);
      chk($sformatf("tbl%0d_addr", i), addr_of(tbl[i].k), tbl[i].ad);
    end
    chk("c_idle_addr", addr_c, 14);
    run_v[2] = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      wait_v(2, i);
      chk($sformatf("c_wrap_addr%0d", i), addr_c, (14 + i) & 15);
    end
    wait_v(0, 70);
    rst_v[0] = 1'b1;
    repeat (2) tick();
    rst_v[0] = 1'b0;
    n0 = cyc;
    v0 = vcnt[0];
    wait_v(0, v0 + 1);
    chk("restart_latency_a", lastv[0] - n0, 11);
    wait_v(0, v0 + 2);
    tick();
    rst_v[0] = 1'b1;
    #1;
    chk("midwait_reset_flags", flags_of(0), 0);
    chk("midwait_reset_valid", val_v[0], 0);
    chk("midwait_reset_addr", addr_a, 0);
    v1 = vcnt[0];
    tick();
    rst_v[0] = 1'b0;
    n0 = cyc;
    wait_v(0, v1 + 1);
    chk("after_reset_latency", lastv[0] - n0, 11);
    v0 = vcnt[1];
    wait_v(1, v0 + 1);
    repeat (3) tick();
    run_v[1] = 1'b0;
    v1 = vcnt[1];
    repeat (30) tick();
    chk("drop_one_more", vcnt[1], v1 + 1);
    chk("drop_idle_addr", addr_b, ptr[1]);
    n0 = cyc;
    run_v[1] = 1'b1;
    wait_v(1, v1 + 2);
    chk("resume_latency_b", lastv[1] - n0, 11);
    repeat (5) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
